voice_allocator: RTL

//  Polyphonic voice controller sitting between the note-event source and a bank
//  of NUM_VOICES oscillator instances. Accepts note-on/off events over a

---
 rtl/voice_allocator_pkg.sv | 16 +
 rtl/voice_slot.sv | 75 +++++++
 rtl/voice_allocator.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/voice_allocator_pkg.sv
// Shared definitions for the voice allocator: FSM states and width defaults
// common to the oscillator and note-source blocks.
package voice_allocator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  localparam int NUM_VOICES_DEF = 4;
  localparam int FREQ_W_DEF     = 20;
  localparam int NOTE_W_DEF     = 7;
  localparam int AGE_W_DEF      = 8;

endpackage

// File: rtl/voice_slot.sv
// One oscillator voice: gate, note, frequency and a saturating age counter.
// Command priority: clear > load > release > age increment.
module voice_slot
  import voice_allocator_pkg::*;
#(
  parameter int FREQ_W = FREQ_W_DEF,
  parameter int NOTE_W = NOTE_W_DEF,
  parameter int AGE_W  = AGE_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              rel,
  input  logic              age_inc,
  input  logic              clear,
  input  logic [NOTE_W-1:0] load_note,
  input  logic [FREQ_W-1:0] load_freq,
  output logic              gate,
  output logic [NOTE_W-1:0] note,
  output logic [FREQ_W-1:0] freq,
  output logic [AGE_W-1:0]  age
);

  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  logic              gate_q, gate_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic [FREQ_W-1:0] freq_q, freq_d;
  logic [AGE_W-1:0]  age_q,  age_d;

  // Next-state for the voice registers from the allocator's commands.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    gate_d = gate_q;
    note_d = note_q;
    freq_d = freq_q;
    age_d  = age_q;
    if (clear) begin
      gate_d = 1'b0;
      age_d  = '0;
    end else if (load) begin
      gate_d = 1'b1;
      note_d = load_note;
      freq_d = load_freq;
      age_d  = '0;
    end else if (rel) begin
      // Note and frequency stay put so the release tail keeps its pitch.
      gate_d = 1'b0;
    end else if (age_inc && (age_q != AGE_MAX)) begin
      age_d = age_q + 1'b1;
    end
  end

  // Voice register bank with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (reset) begin
      gate_q <= 1'b0;
      note_q <= '0;
      freq_q <= '0;
      age_q  <= '0;
    end else begin
      gate_q <= gate_d;
      note_q <= note_d;
      freq_q <= freq_d;
      age_q  <= age_d;
    end
  end

  assign gate = gate_q;
  assign note = note_q;
  assign freq = freq_q;
  assign age  = age_q;

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: accepts note events, scans the voices one per
// cycle and commits retrigger / free / steal-oldest assignment or a release.
module voice_allocator
  import voice_allocator_pkg::*;
#(
  parameter int NUM_VOICES = NUM_VOICES_DEF,
  parameter int FREQ_W     = FREQ_W_DEF,
  parameter int NOTE_W     = NOTE_W_DEF,
  parameter int AGE_W      = AGE_W_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         evt_valid,
  output logic                         evt_ready,
  input  logic                         evt_on,
  input  logic [NOTE_W-1:0]            evt_note,
  input  logic [FREQ_W-1:0]            evt_freq,
  input  logic                         all_off,
  output logic [NUM_VOICES-1:0]        voice_gate,
  output logic [NUM_VOICES*FREQ_W-1:0] voice_freq,
  output logic [NUM_VOICES-1:0]        voice_osc_reset,
  output logic                         steal_pulse,
  output logic                         drop_pulse
);

  localparam int              IDX_W    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    ev_on_q, ev_on_d;
  logic [NOTE_W-1:0]       ev_note_q, ev_note_d;
  logic [FREQ_W-1:0]       ev_freq_q, ev_freq_d;
  logic                    match_vld_q, match_vld_d;
  logic [IDX_W-1:0]        match_idx_q, match_idx_d;
  logic                    free_vld_q, free_vld_d;
  logic [IDX_W-1:0]        free_idx_q, free_idx_d;
  logic                    old_vld_q, old_vld_d;
  logic [IDX_W-1:0]        old_idx_q, old_idx_d;
  logic [AGE_W-1:0]        old_age_q, old_age_d;
  logic [NUM_VOICES-1:0]   osc_reset_q, osc_reset_d;
  logic                    steal_q, steal_d;
  logic                    drop_q, drop_d;

  logic [NUM_VOICES-1:0]   slot_gate, slot_load, slot_rel, slot_age_inc;
  logic [NOTE_W-1:0]       slot_note [NUM_VOICES];
  logic [FREQ_W-1:0]       slot_freq [NUM_VOICES];
  logic [AGE_W-1:0]        slot_age  [NUM_VOICES];
  logic [IDX_W-1:0]        target;

  // Events are only taken in IDLE, never during panic or reset.
  assign evt_ready = (state_q == ST_IDLE) && !all_off && !reset;

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_slot
    voice_slot #(
      .FREQ_W (FREQ_W),
      .NOTE_W (NOTE_W),
      .AGE_W  (AGE_W)
    ) u_slot (
      .clk       (clk),
      .reset     (reset),
      .load      (slot_load[i]),
      .rel       (slot_rel[i]),
      .age_inc   (slot_age_inc[i]),
      .clear     (all_off),
      .load_note (ev_note_q),
      .load_freq (ev_freq_q),
      .gate      (slot_gate[i]),
      .note      (slot_note[i]),
      .freq      (slot_freq[i]),
      .age       (slot_age[i])
    );
    assign voice_freq[i*FREQ_W +: FREQ_W] = slot_freq[i];
  end

  // FSM next state, scan tracking and commit decisions.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    ev_on_d      = ev_on_q;
    ev_note_d    = ev_note_q;
    ev_freq_d    = ev_freq_q;
    match_vld_d  = match_vld_q;
    match_idx_d  = match_idx_q;
    free_vld_d   = free_vld_q;
    free_idx_d   = free_idx_q;
    old_vld_d    = old_vld_q;
    old_idx_d    = old_idx_q;
    old_age_d    = old_age_q;
    osc_reset_d  = '0;
    steal_d      = 1'b0;
    drop_d       = 1'b0;
    slot_load    = '0;
    slot_rel     = '0;
    slot_age_inc = '0;
    target       = '0;

    if (all_off) begin
      // Panic aborts any latched event; the slots clear themselves.
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (evt_valid && evt_ready) begin
            ev_on_d     = evt_on;
            ev_note_d   = evt_note;
            ev_freq_d   = evt_freq;
            idx_d       = '0;
            match_vld_d = 1'b0;
            free_vld_d  = 1'b0;
            old_vld_d   = 1'b0;
            old_age_d   = '0;
            state_d     = ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (!match_vld_q && slot_gate[idx_q] && (slot_note[idx_q] == ev_note_q)) begin
            match_vld_d = 1'b1;
            match_idx_d = idx_q;
          end
          if (!free_vld_q && !slot_gate[idx_q]) begin
            free_vld_d = 1'b1;
            free_idx_d = idx_q;
          end
          // Strictly greater keeps the lowest index among equal (or saturated) ages.
          if (slot_gate[idx_q] && (!old_vld_q || (slot_age[idx_q] > old_age_q))) begin
            old_vld_d = 1'b1;
            old_idx_d = idx_q;
            old_age_d = slot_age[idx_q];
          end
          if (idx_q == LAST_IDX) state_d = ST_COMMIT;
          else                   idx_d   = idx_q + 1'b1;
        end
        ST_COMMIT: begin
          state_d = ST_IDLE;
          if (ev_on_q) begin
            if (match_vld_q)     target = match_idx_q;
            else if (free_vld_q) target = free_idx_q;
            else begin
              target  = old_idx_q;
              steal_d = 1'b1;
            end
            slot_load[target]   = 1'b1;
            osc_reset_d[target] = 1'b1;
            for (int i = 0; i < NUM_VOICES; i++) begin
              if (IDX_W'(i) != target) slot_age_inc[i] = slot_gate[i];
            end
          end else if (match_vld_q) begin
            slot_rel[match_idx_q] = 1'b1;
          end else begin
            drop_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Control registers; every flop is reset, including the latched event.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      ev_on_q     <= 1'b0;
      ev_note_q   <= '0;
      ev_freq_q   <= '0;
      match_vld_q <= 1'b0;
      match_idx_q <= '0;
      free_vld_q  <= 1'b0;
      free_idx_q  <= '0;
      old_vld_q   <= 1'b0;
      old_idx_q   <= '0;
      old_age_q   <= '0;
      osc_reset_q <= '0;
      steal_q     <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      ev_on_q     <= ev_on_d;
      ev_note_q   <= ev_note_d;
      ev_freq_q   <= ev_freq_d;
      match_vld_q <= match_vld_d;
      match_idx_q <= match_idx_d;
      free_vld_q  <= free_vld_d;
      free_idx_q  <= free_idx_d;
      old_vld_q   <= old_vld_d;
      old_idx_q   <= old_idx_d;
      old_age_q   <= old_age_d;
      osc_reset_q <= osc_reset_d;
      steal_q     <= steal_d;
      drop_q      <= drop_d;
    end
  end

  assign voice_gate      = slot_gate;
  assign voice_osc_reset = osc_reset_q;
  assign steal_pulse     = steal_q;
  assign drop_pulse      = drop_q;

endmodule
